// File: rtl/h264_mb_scheduler.sv
// Frame-level macroblock sequencer between the fetch unit and the intra 4x4 unit.
// Latency: first fetch_start_o 1 cycle after start is taken; intra handoff 1 cycle after fetch and intra are both ready.
// Backpressure: fetch of MB n+1 waits in F_HOLD until intra has finished MB n; only one fetched MB waits beyond the one in intra.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, qp_i                      frame request (taken only when idle) and its QP
//   fetch_start_o, fetch_mb_x/y_o    one-cycle fetch request and the MB being fetched
//   fetch_done_i                     fetch unit has the Y/U/V matrices ready
//   intra_start_o, intra_mb_x/y_o    one-cycle handoff pulse and the MB handed to intra
//   intra_ready_i                    intra unit finished its current MB
//   qp_o, busy_o, frame_done_o       frame QP, frame in progress, end-of-frame pulse
//   mb_count_o                       MBs completed by intra in this frame
module h264_mb_scheduler #(
  parameter int MB_W       = 22,
  parameter int MB_H       = 18,
  parameter int QP_DEFAULT = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  qp_i,
  output logic        fetch_start_o,
  output logic [5:0]  fetch_mb_x_o,
  output logic [5:0]  fetch_mb_y_o,
  input  logic        fetch_done_i,
  output logic        intra_start_o,
  output logic [5:0]  intra_mb_x_o,
  output logic [5:0]  intra_mb_y_o,
  input  logic        intra_ready_i,
  output logic [5:0]  qp_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [11:0] mb_count_o
);

  localparam logic [5:0]  LAST_X   = 6'(MB_W - 1);
  localparam logic [5:0]  LAST_Y   = 6'(MB_H - 1);
  localparam logic [11:0] MB_TOTAL = 12'(MB_W * MB_H);

  typedef enum logic [2:0] {F_IDLE, F_REQ, F_WAIT, F_HOLD, F_DONE} fstate_t;
  typedef enum logic       {I_IDLE, I_BUSY} istate_t;

  fstate_t fstate;
  istate_t istate;

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate        <= F_IDLE;
      istate        <= I_IDLE;
      fetch_start_o <= 1'b0;
      fetch_mb_x_o  <= 6'd0;
      fetch_mb_y_o  <= 6'd0;
      intra_start_o <= 1'b0;
      intra_mb_x_o  <= 6'd0;
      intra_mb_y_o  <= 6'd0;
      qp_o          <= 6'(QP_DEFAULT);
      busy_o        <= 1'b0;
      frame_done_o  <= 1'b0;
      mb_count_o    <= 12'd0;
    end else begin
      fetch_start_o <= 1'b0;
      intra_start_o <= 1'b0;
      frame_done_o  <= 1'b0;

      // Intra tracker: completion is counted on the edge that sees intra_ready_i,
      // so the earliest next handoff is one cycle later (never back-to-back).
      if (istate == I_BUSY && intra_ready_i) begin
        istate     <= I_IDLE;
        mb_count_o <= mb_count_o + 12'd1;
      end

      case (fstate)
        F_IDLE: begin
          if (start) begin
            qp_o         <= qp_i;
            fetch_mb_x_o <= 6'd0;
            fetch_mb_y_o <= 6'd0;
            intra_mb_x_o <= 6'd0;
            intra_mb_y_o <= 6'd0;
            mb_count_o   <= 12'd0;
            busy_o       <= 1'b1;
            fstate       <= F_REQ;
          end
        end
        F_REQ: begin
          fetch_start_o <= 1'b1;
          fstate        <= F_WAIT;
        end
        F_WAIT: begin
          if (fetch_done_i) fstate <= F_HOLD;
        end
        F_HOLD: begin
          // Handoff: intra captures the matrices on intra_start_o, which frees
          // the fetch unit to start on the next MB in the following cycle.
          if (istate == I_IDLE) begin
            intra_start_o <= 1'b1;
            intra_mb_x_o  <= fetch_mb_x_o;
            intra_mb_y_o  <= fetch_mb_y_o;
            istate        <= I_BUSY;
            if (fetch_mb_x_o == LAST_X && fetch_mb_y_o == LAST_Y) begin
              fstate <= F_DONE;
            end else begin
              if (fetch_mb_x_o == LAST_X) begin
                fetch_mb_x_o <= 6'd0;
                fetch_mb_y_o <= fetch_mb_y_o + 6'd1;
              end else begin
                fetch_mb_x_o <= fetch_mb_x_o + 6'd1;
              end
              fstate <= F_REQ;
            end
          end
        end
        F_DONE: begin
          // The last MB is the only one left in intra; its completion ends the frame.
          if (istate == I_BUSY && intra_ready_i && mb_count_o == MB_TOTAL - 12'd1) begin
            frame_done_o <= 1'b1;
            busy_o       <= 1'b0;
            fstate       <= F_IDLE;
          end
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

endmodule

// File: doc/h264_mb_scheduler.md
Name: h264_mb_scheduler

Overview:
- Frame-level macroblock sequencer sitting between the fetch unit and the intra 4x4 unit inside the H.264 top.
- Walks MB coordinates in raster order and pulses fetch start per MB.
- Hands each fetched MB to the intra unit, overlapping the fetch of MB n+1 with intra processing of MB n, and reports frame completion.
- Owns the QP value presented to the datapath.

Parameters:
- MB_W, 22, frame width in macroblocks (1..63)
- MB_H, 18, frame height in macroblocks (1..63)
- QP_DEFAULT, 27, QP value after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one frame; level sampled, acted on only when idle
- qp_i  in  6  QP for the coming frame, latched on accepted start
- fetch_start_o  out  1  one-cycle pulse: fetch MB at fetch_mb_x_o/fetch_mb_y_o
- fetch_mb_x_o  out  6  MB column being fetched
- fetch_mb_y_o  out  6  MB row being fetched
- fetch_done_i  in  1  fetch unit matrix_valid pulse: Y/U/V matrices ready
- intra_start_o  out  1  one-cycle pulse: intra unit latches matrices and coordinates
- intra_mb_x_o  out  6  MB column handed to intra
- intra_mb_y_o  out  6  MB row handed to intra
- intra_ready_i  in  1  intra unit finished current MB (pulse)
- qp_o  out  6  frame QP
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse after last MB completes intra
- mb_count_o  out  12  MBs completed by intra this frame

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: all pulses 0, coordinates 0, busy_o 0, mb_count_o 0, qp_o = QP_DEFAULT. Both FSMs go to idle.
- Fetch FSM states:
  - F_IDLE: on start=1, latch qp_i into qp_o, clear coordinates and mb_count_o, set busy_o, go to F_REQ.
  - F_REQ: assert fetch_start_o for exactly one cycle, go to F_WAIT. First fetch_start_o occurs 1 cycle after start is sampled.
  - F_WAIT: wait for fetch_done_i, then go to F_HOLD. fetch_done_i in any other state is ignored.
  - F_HOLD: wait for the intra FSM to be I_IDLE. Then, in the same cycle:
    - pulse intra_start_o;
    - copy fetch coordinates to intra_mb_x_o/intra_mb_y_o;
    - if this was the last MB (x=MB_W-1, y=MB_H-1) go to F_DONE;
    - else advance the coordinates and go to F_REQ.
  - F_DONE: wait for the intra FSM to reach I_IDLE with all MBs counted, then go to F_IDLE.
- Coordinate advance: x+1. If x=MB_W-1, x wraps to 0 and y increments. fetch_mb_x_o/fetch_mb_y_o are stable from the fetch_start_o cycle until the next advance.
- Intra FSM states:
  - I_IDLE: on intra_start_o, go to I_BUSY.
  - I_BUSY: on intra_ready_i, increment mb_count_o and go to I_IDLE. intra_ready_i in I_IDLE is ignored.
- Handoff rules:
  - Intra FSM is I_IDLE in the same cycle it receives intra_ready_i. The handoff itself occurs the cycle after, so there are no back-to-back intra_start_o pulses and intra_start_o never coincides with intra_ready_i.
  - If fetch_done_i and intra_ready_i arrive in the same cycle, both are honoured. The handoff occurs 1 cycle later, from F_HOLD.
  - Overlap: fetch of MB n+1 starts the cycle after intra_start_o for MB n. The intra unit must capture the matrices on intra_start_o.
- Completion:
  - frame_done_o pulses 1 cycle after the intra_ready_i that brings mb_count_o to MB_W*MB_H.
  - busy_o drops in that same cycle.
  - mb_count_o holds its final value until the next accepted start.
- start while busy_o=1 is ignored; qp_o is unchanged mid-frame.
- rst mid-frame: all state returns to reset values on that edge. In-flight fetch_done_i/intra_ready_i after reset are ignored, because both FSMs are idle.
- Degenerate 1x1 frame: one fetch, one handoff, F_DONE, then frame_done_o.

Test Plan:
- MB_W=2, MB_H=2, qp_i=30, start pulse; fetch_done_i 5 cycles after each fetch_start_o; intra_ready_i 8 cycles after each intra_start_o -> fetch coordinates sequence (0,0),(1,0),(0,1),(1,1); qp_o=30; mb_count_o ends at 4; single frame_done_o; busy_o low after.
- Fast intra (ready 1 cycle after start), slow fetch (20 cycles) -> intra_start_o exactly once per fetch_done_i; F_HOLD lasts 1 cycle each time.
- Slow intra (30 cycles), fast fetch (2 cycles) -> fetch stalls in F_HOLD; only one fetch is ever outstanding beyond the MB in intra; no intra_start_o while intra busy.
- fetch_done_i and intra_ready_i in the same cycle -> intra_start_o exactly 1 cycle later; mb_count_o increments once.
- start asserted mid-frame with qp_i=10 -> ignored, qp_o unchanged. Then rst mid-frame -> next cycle busy_o=0, coordinates 0, qp_o=27. A stray intra_ready_i after reset leaves mb_count_o at 0.
- MB_W=1, MB_H=1 -> one fetch_start_o, one intra_start_o; frame_done_o 1 cycle after intra_ready_i; mb_count_o=1.
